hazard_unit_mc: RTL and testbench

- Next-generation hazard unit for the 5-stage pipelined ARM core (F/D/E/M/W).
- Covers EX forwarding from M and W, load-use stalls, and branch/PC-write flushes.
- Adds parametrised register address width and excludes the PC register from forwarding and load-use matching.
- Adds a cycle-counting FSM that holds a multi-cycle multiply/divide op in E for MUL_LAT cycles while M receives bubbles.
- Sits beside the datapath; all inputs come from pipeline registers, all outputs drive stall/flush/mux controls.

---
 rtl/hazard_unit_mc.sv | 188 ++++++++++++++++++
 tb/tb_hazard_unit_mc.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// ---------------------------------------------------------------------------
// hazard_unit_mc
//   Hazard unit for the 5-stage (F/D/E/M/W) pipelined ARM core.
//   Handles EX-stage operand forwarding from M and W, load-use stalls,
//   PC-write / branch flushes, and holds multi-cycle multiply/divide ops in
//   E for MUL_LAT cycles while M receives bubbles.
//
//   The PC register (PC_REG) reads as PC+8, so it is never forwarded and
//   never takes part in load-use matching.
//
// Parameters:
//   AW       register address width (2**AW registers)
//   MUL_LAT  total cycles a multi-cycle op occupies E (2..15)
//   PC_REG   register index of the PC
//
// Ports:
//   clk, reset                   clock (rising edge), async active-high reset
//   RA1D, RA2D                   source registers in D
//   RA1E, RA2E                   source registers in E
//   WA3E, WA3M, WA3W             destination registers in E/M/W
//   RegWriteM, RegWriteW         destination write enables in M/W
//   MemtoRegE                    E holds a load
//   PCSrcD/E/M/W                 stage writes the PC
//   BranchTakenE                 branch in E resolved taken
//   MulStartE                    E holds a multi-cycle op
//   ForwardAE, ForwardBE         00 regfile, 01 W result, 10 M result
//   StallF, StallD, StallE       hold F/D/E pipeline registers
//   FlushD, FlushE, FlushM       bubble D/E/M pipeline registers
//   MulBusy                      multi-cycle FSM is in BUSY
//   MulDone                      final E cycle of a multi-cycle op
//
// Optional feature (macro HAZARD_PERF_EN):
//   StallCnt (32 bit)  cycles with StallF=1, saturating
//   MulCnt   (16 bit)  number of MulDone pulses, wrapping
// ---------------------------------------------------------------------------
module hazard_unit_mc #(
    parameter int AW      = 4,
    parameter int MUL_LAT = 4,
    parameter int PC_REG  = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] RA1D,
    input  logic [AW-1:0] RA2D,
    input  logic [AW-1:0] RA1E,
    input  logic [AW-1:0] RA2E,
    input  logic [AW-1:0] WA3E,
    input  logic [AW-1:0] WA3M,
    input  logic [AW-1:0] WA3W,
    input  logic          RegWriteM,
    input  logic          RegWriteW,
    input  logic          MemtoRegE,
    input  logic          PCSrcD,
    input  logic          PCSrcE,
    input  logic          PCSrcM,
    input  logic          PCSrcW,
    input  logic          BranchTakenE,
    input  logic          MulStartE,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic          StallF,
    output logic          StallD,
    output logic          StallE,
    output logic          FlushD,
    output logic          FlushE,
    output logic          FlushM,
    output logic          MulBusy,
    output logic          MulDone
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]   StallCnt,
    output logic [15:0]   MulCnt
`endif
);

    localparam logic [AW-1:0] PC_IDX   = AW'(PC_REG);
    // The start cycle is spent in IDLE, and the final cycle at cnt==0,
    // so BUSY is entered with MUL_LAT-2 remaining hold cycles.
    localparam logic [3:0]    CNT_INIT = 4'(MUL_LAT - 2);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;

    logic       mul_hold;
    logic       ldr_stall_d;
    logic       pc_wr_pending_f;

    // ---------------- forwarding ----------------
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (RA1E == WA3M) && (RA1E != PC_IDX))
            ForwardAE = 2'b10;
        else if (RegWriteW && (RA1E == WA3W) && (RA1E != PC_IDX))
            ForwardAE = 2'b01;

        ForwardBE = 2'b00;
        if (RegWriteM && (RA2E == WA3M) && (RA2E != PC_IDX))
            ForwardBE = 2'b10;
        else if (RegWriteW && (RA2E == WA3W) && (RA2E != PC_IDX))
            ForwardBE = 2'b01;
    end

    // ---------------- load-use / PC write ----------------
    assign ldr_stall_d = MemtoRegE &&
                         (((RA1D == WA3E) && (RA1D != PC_IDX)) ||
                          ((RA2D == WA3E) && (RA2D != PC_IDX)));

    assign pc_wr_pending_f = PCSrcD | PCSrcE | PCSrcM;

    // ---------------- multi-cycle FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mul_hold   = 1'b0;
        MulDone    = 1'b0;
        unique case (state)
            IDLE: begin
                // A taken branch in the same cycle wins; the op is squashed.
                if (MulStartE && !BranchTakenE) begin
                    mul_hold   = 1'b1;
                    state_next = BUSY;
                    cnt_next   = CNT_INIT;
                end
            end
            BUSY: begin
                // MulStartE is the same held instruction here and is ignored.
                if (cnt != '0) begin
                    mul_hold = 1'b1;
                    cnt_next = cnt - 4'd1;
                end else begin
                    MulDone    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        // While reset is asserted the hold and done indications are
        // suppressed so every output follows the inputs directly.
        if (reset) begin
            mul_hold = 1'b0;
            MulDone  = 1'b0;
        end
    end

    // ---------------- control outputs ----------------
    assign StallF  = ldr_stall_d | pc_wr_pending_f | mul_hold;
    assign StallD  = ldr_stall_d | mul_hold;
    assign StallE  = mul_hold;
    assign FlushM  = mul_hold;
    assign FlushD  = (pc_wr_pending_f | PCSrcW | BranchTakenE) & ~mul_hold;
    assign FlushE  = (ldr_stall_d | BranchTakenE) & ~mul_hold;
    assign MulBusy = (state == BUSY);

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCnt <= '0;
            MulCnt   <= '0;
        end else begin
            if (StallF && (StallCnt != '1))
                StallCnt <= StallCnt + 32'd1;
            if (MulDone)
                MulCnt <= MulCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteM, RegWriteW, MemtoRegE;
    logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW;
    logic       BranchTakenE, MulStartE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic       MulBusy, MulDone;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCnt;
    logic [15:0] MulCnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy, MulDone}
    logic [7:0] flags;
    assign flags = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy, MulDone};

    always #5 clk = ~clk;

    hazard_unit_mc #(
        .AW      (4),
        .MUL_LAT (4),
        .PC_REG  (15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .RA1E         (RA1E),
        .RA2E         (RA2E),
        .WA3E         (WA3E),
        .WA3M         (WA3M),
        .WA3W         (WA3W),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegE    (MemtoRegE),
        .PCSrcD       (PCSrcD),
        .PCSrcE       (PCSrcE),
        .PCSrcM       (PCSrcM),
        .PCSrcW       (PCSrcW),
        .BranchTakenE (BranchTakenE),
        .MulStartE    (MulStartE),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushM       (FlushM),
        .MulBusy      (MulBusy),
        .MulDone      (MulDone)
`ifdef HAZARD_PERF_EN
        ,
        .StallCnt     (StallCnt),
        .MulCnt       (MulCnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        RA1D = 4'd0; RA2D = 4'd1; RA1E = 4'd0; RA2E = 4'd1;
        WA3E = 4'd2; WA3M = 4'd2; WA3W = 4'd2;
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
        PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
        BranchTakenE = 1'b0; MulStartE = 1'b0;
    endtask

    // Advance one clock: inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Full MUL_LAT=4 sequence; MulStartE stays high while the op is held.
    task automatic mul_seq(input string tag, input logic pcw);
        logic [7:0] exp_tab [4];
        exp_tab[0] = 8'b1110_0100;
        exp_tab[1] = 8'b1110_0110;
        exp_tab[2] = 8'b1110_0110;
        exp_tab[3] = {3'b000, pcw, 4'b0011};
        MulStartE = 1'b1;
        PCSrcW    = pcw;
        for (int c = 0; c < 4; c++) begin
            #2;
            check($sformatf("%s_c%0d", tag, c), {24'd0, flags}, {24'd0, exp_tab[c]});
            next_cycle();
        end
        MulStartE = 1'b0;
        PCSrcW    = 1'b0;
        #2;
        check({tag, "_idle"}, {24'd0, flags}, 32'd0);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #12;
        check("reset_flags", {24'd0, flags}, 32'd0);
        check("reset_fwd", {28'd0, ForwardAE, ForwardBE}, 32'd0);
        reset = 1'b0;
        next_cycle();

        // Forwarding: M has priority over W
        RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
        #2; check("fwdA_M", {30'd0, ForwardAE}, 32'd2);
        RegWriteM = 1'b0;
        #2; check("fwdA_W", {30'd0, ForwardAE}, 32'd1);
        RegWriteW = 1'b0;
        #2; check("fwdA_none", {30'd0, ForwardAE}, 32'd0);
        RA2E = 4'd7; WA3W = 4'd7; RegWriteW = 1'b1;
        #2; check("fwdB_W", {30'd0, ForwardBE}, 32'd1);
        // PC never forwarded
        clear_inputs();
        RA2E = 4'd15; WA3M = 4'd15; RegWriteM = 1'b1;
        #2; check("fwdB_pc", {30'd0, ForwardBE}, 32'd0);
        WA3W = 4'd15; RegWriteW = 1'b1;
        #2; check("fwdB_pc_w", {30'd0, ForwardBE}, 32'd0);

        // Load-use on RA2D
        clear_inputs();
        MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
        #2; check("ldr_use", {24'd0, flags}, {24'd0, 8'b1100_1000});
        next_cycle();
        MemtoRegE = 1'b0;
        #2; check("ldr_after", {24'd0, flags}, 32'd0);
        // PC excluded from load-use
        MemtoRegE = 1'b1; WA3E = 4'd15; RA1D = 4'd15;
        #2; check("ldr_pc", {24'd0, flags}, 32'd0);
        clear_inputs();

        // PC write in D: stall F, flush D
        PCSrcD = 1'b1;
        #2; check("pcsrcD", {24'd0, flags}, {24'd0, 8'b1001_0000});
        PCSrcD = 1'b0; PCSrcW = 1'b1;
        #2; check("pcsrcW", {24'd0, flags}, {24'd0, 8'b0001_0000});
        PCSrcW = 1'b0;
        next_cycle();

        // Multi-cycle op
        mul_seq("mul", 1'b0);
        next_cycle();
        mul_seq("mul_pcw", 1'b1);
        next_cycle();

        // Reset mid-op
        MulStartE = 1'b1;
        #2; check("rst_mid_c0", {24'd0, flags}, {24'd0, 8'b1110_0100});
        next_cycle();
        #1; check("rst_mid_busy", {31'd0, MulBusy}, 32'd1);
        reset = 1'b1;
        #1; check("rst_mid_flags", {24'd0, flags}, 32'd0);
        next_cycle();
        #1; check("rst_hold_flags", {24'd0, flags}, 32'd0);
        MulStartE = 1'b0;
        reset = 1'b0;
        #1; check("rst_release", {24'd0, flags}, 32'd0);
        next_cycle();
        mul_seq("mul_restart", 1'b0);
        next_cycle();

        // Taken branch wins over MulStartE
        MulStartE = 1'b1; BranchTakenE = 1'b1;
        #2; check("br_vs_mul", {24'd0, flags}, {24'd0, 8'b0001_1000});
        next_cycle();
        MulStartE = 1'b0; BranchTakenE = 1'b0;
        #2; check("br_stays_idle", {24'd0, flags}, 32'd0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
